// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// dmem_responder_pkg : address map, STATUS bit positions and region decode
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [3:0] OFF_TX       = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_CYCLE_LO = 4'h8;
    localparam logic [3:0] OFF_CYCLE_HI = 4'hC;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_BADADDR   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_TX,
        REGION_STATUS,
        REGION_CYCLE_LO,
        REGION_CYCLE_HI,
        REGION_UNMAPPED
    } region_e;

    // addr[1:0] never participates: every access is a whole word.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [32:0] ram_bytes,
                                              input logic [27:0] mmio_tag);
        region_e r;
        r = REGION_UNMAPPED;
        if ({1'b0, addr} < ram_bytes) begin
            r = REGION_RAM;
        end else if (addr[31:4] == mmio_tag) begin
            case ({addr[3:2], 2'b00})
                OFF_TX:       r = REGION_TX;
                OFF_STATUS:   r = REGION_STATUS;
                OFF_CYCLE_LO: r = REGION_CYCLE_LO;
                default:      r = REGION_CYCLE_HI;
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : core data port plus console byte stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    modport slave (
        input  memwrite, addr, write_data, con_ready,
        output read_data, con_valid, con_data
    );

    modport master (
        output memwrite, addr, write_data, con_ready,
        input  read_data, con_valid, con_data
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder_byte_fifo.sv
// ============================================================================
// byte_fifo : circular buffer with wrapping pointers and an explicit count
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rstn,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [WIDTH-1:0]                head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // An empty FIFO presents zero rather than a stale slot.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : data RAM, 64-bit cycle counter and console TX FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    dmem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem_q [DEPTH_WORDS];
    region_e       region;
    logic [AW-1:0] ram_idx;
    logic          tx_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          wr_status, wr_cycle, wr_unmapped;
    logic          ovf_q, ovf_d;
    logic          badaddr_q, badaddr_d;
    logic [63:0]   cycle_q, cycle_d;
    logic [31:0]   status;

    always_comb begin
        region  = decode_region(bus.addr, RAM_BYTES, MMIO_BASE[31:4]);
        ram_idx = bus.addr[AW+1:2];
    end

    always_comb begin
        tx_push     = bus.memwrite && (region == REGION_TX);
        wr_status   = bus.memwrite && (region == REGION_STATUS);
        wr_cycle    = bus.memwrite && ((region == REGION_CYCLE_LO) ||
                                       (region == REGION_CYCLE_HI));
        wr_unmapped = bus.memwrite && (region == REGION_UNMAPPED);
        fifo_pop    = !fifo_empty && bus.con_ready;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_byte_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (bus.write_data[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.con_valid = !fifo_empty;
    assign bus.con_data  = fifo_head;

    always_comb begin
        status                                   = '0;
        status[ST_FULL]                          = fifo_full;
        status[ST_EMPTY]                         = fifo_empty;
        status[ST_OVF]                           = ovf_q;
        status[ST_BADADDR]                       = badaddr_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]       = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        bus.read_data = '0;
        case (region)
            REGION_RAM:      bus.read_data = mem_q[ram_idx];
            REGION_STATUS:   bus.read_data = status;
            REGION_CYCLE_LO: bus.read_data = cycle_q[31:0];
            REGION_CYCLE_HI: bus.read_data = cycle_q[63:32];
            default:         bus.read_data = '0;
        endcase
    end

    // A push into a full FIFO is only lost when nothing drains that cycle.
    always_comb begin
        ovf_d     = ovf_q;
        badaddr_d = badaddr_q;
        cycle_d   = cycle_q + 64'd1;
        if (wr_status && bus.write_data[ST_OVF])     ovf_d     = 1'b0;
        if (tx_push && fifo_full && !fifo_pop)       ovf_d     = 1'b1;
        if (wr_status && bus.write_data[ST_BADADDR]) badaddr_d = 1'b0;
        if (wr_unmapped)                             badaddr_d = 1'b1;
        if (wr_cycle)                                cycle_d   = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q     <= 1'b0;
            badaddr_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            ovf_q     <= ovf_d;
            badaddr_q <= badaddr_d;
            cycle_q   <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.memwrite && (region == REGION_RAM)) mem_q[ram_idx] <= bus.write_data;
    end

endmodule

`default_nettype wire
